// File: rtl/demux_1x4_32bit_reg_pkg.sv
// Shared types and constants for the registered 1-to-4 demux.
// Optional DEMUX_STATS_EN adds per-channel drain counters.
package demux_1x4_32bit_reg_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int NCH       = 4;
  localparam int CNT_W     = 16;

  typedef logic [1:0] ch_idx_t;

  typedef enum logic [1:0] {
    CH_A = 2'd0,
    CH_B = 2'd1,
    CH_C = 2'd2,
    CH_D = 2'd3
  } ch_e;

endpackage

// File: rtl/demux_slot.sv
// One-entry holding register with valid/ready handshake.
// A drain and a load in the same cycle keep the slot full with new data.
module demux_slot #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             drain,
  output logic             ready_out,
  output logic             full,
  output logic [WIDTH-1:0] data_out
);

  logic             r_full;
  logic [WIDTH-1:0] r_data;

  assign ready_out = !r_full | drain;
  assign full      = r_full;
  assign data_out  = r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (load) begin
      r_full <= 1'b1;
      r_data <= data_in;
    end else if (r_full & drain) begin
      r_full <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_1x4_32bit_reg.sv
// Registered 1-to-4 demux, independent per-channel backpressure.
// `define DEMUX_STATS_EN to add the xfer_count drain counters.
module demux_1x4_32bit_reg
  import demux_1x4_32bit_reg_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] inp,
  input  logic             sel0,
  input  logic             sel1,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] outa,
  output logic [WIDTH-1:0] outb,
  output logic [WIDTH-1:0] outc,
  output logic [WIDTH-1:0] outd,
  output logic [NCH-1:0]   out_valid,
  input  logic [NCH-1:0]   out_ready
`ifdef DEMUX_STATS_EN
  ,
  output logic [NCH*CNT_W-1:0] xfer_count
`endif
);

  ch_idx_t          w_idx;
  logic [NCH-1:0]   w_rdy;
  logic [NCH-1:0]   w_full;
  logic [NCH-1:0]   w_load;
  logic [WIDTH-1:0] w_data [NCH];

  assign w_idx    = {sel1, sel0};
  assign in_ready = w_rdy[w_idx];

  for (genvar k = 0; k < NCH; k++) begin : g_slot
    assign w_load[k] = in_valid & in_ready & (w_idx == ch_idx_t'(k));

    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (w_load[k]),
      .data_in   (inp),
      .drain     (out_ready[k]),
      .ready_out (w_rdy[k]),
      .full      (w_full[k]),
      .data_out  (w_data[k])
    );
  end

  assign out_valid = w_full;
  assign outa      = w_data[CH_A];
  assign outb      = w_data[CH_B];
  assign outc      = w_data[CH_C];
  assign outd      = w_data[CH_D];

`ifdef DEMUX_STATS_EN
  // Counters wrap naturally at 16 bits.
  for (genvar k = 0; k < NCH; k++) begin : g_cnt
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
      end else if (w_full[k] & out_ready[k]) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end

    assign xfer_count[k*CNT_W +: CNT_W] = r_cnt;
  end
`endif

endmodule

// File: tb/tb_demux_1x4_32bit_reg.sv
// Directed self-checking bench for demux_1x4_32bit_reg.
// Define DEMUX_STATS_EN to also exercise the drain counters.
module tb_demux_1x4_32bit_reg;

  logic        clk;
  logic        rst_n;
  logic [31:0] inp;
  logic        sel0;
  logic        sel1;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] outa;
  logic [31:0] outb;
  logic [31:0] outc;
  logic [31:0] outd;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
`ifdef DEMUX_STATS_EN
  logic [63:0] xfer_count;
`endif

  int n_chk;
  int n_fail;

  demux_1x4_32bit_reg dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .inp       (inp),
    .sel0      (sel0),
    .sel1      (sel1),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .outa      (outa),
    .outb      (outb),
    .outc      (outc),
    .outd      (outd),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef DEMUX_STATS_EN
    ,
    .xfer_count(xfer_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sel(input logic [1:0] s);
    {sel1, sel0} = s;
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    inp       = '0;
    sel0      = 1'b0;
    sel1      = 1'b0;
    in_valid  = 1'b0;
    out_ready = 4'b0000;

    // Reset state
    #3;
    chk("rst_valid", 64'(out_valid), 64'h0);
    chk("rst_outa", 64'(outa), 64'h0);
    chk("rst_outb", 64'(outb), 64'h0);
    chk("rst_outc", 64'(outc), 64'h0);
    chk("rst_outd", 64'(outd), 64'h0);
    chk("rst_inrdy", 64'(in_ready), 64'h1);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("post_rst_valid", 64'(out_valid), 64'h0);

    // Route one word to channel c
    inp      = 32'hDEADBEEF;
    set_sel(2'b10);
    in_valid = 1'b1;
    #1;
    chk("route_inrdy", 64'(in_ready), 64'h1);
    tick();
    in_valid = 1'b0;
    #1;
    chk("route_valid", 64'(out_valid), 64'h4);
    chk("route_outc", 64'(outc), 64'hDEADBEEF);
    chk("route_outa", 64'(outa), 64'h0);
    chk("route_outb", 64'(outb), 64'h0);
    chk("route_outd", 64'(outd), 64'h0);

    // Backpressure on channel c
    inp      = 32'hCAFEF00D;
    in_valid = 1'b1;
    #1;
    chk("bp_inrdy0", 64'(in_ready), 64'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_outc", 64'(outc), 64'hDEADBEEF);
      chk("bp_hold_valid", 64'(out_valid), 64'h4);
    end
    out_ready = 4'b0100;
    #1;
    chk("bp_inrdy1", 64'(in_ready), 64'h1);
    tick();
    in_valid  = 1'b0;
    out_ready = 4'b0000;
    #1;
    chk("bp_new_outc", 64'(outc), 64'hCAFEF00D);
    chk("bp_new_valid", 64'(out_valid), 64'h4);

    // Stall channel a, stream to channel d
    inp      = 32'hAAAA5555;
    set_sel(2'b00);
    in_valid = 1'b1;
    tick();
    chk("ind_a_valid", 64'(out_valid), 64'h5);
    set_sel(2'b00);
    #1;
    chk("ind_a_inrdy", 64'(in_ready), 64'h0);
    set_sel(2'b11);
    out_ready = 4'b1000;
    for (int i = 1; i <= 8; i++) begin
      inp = 32'(i);
      #1;
      chk("ind_d_inrdy", 64'(in_ready), 64'h1);
      tick();
      chk("ind_outd", 64'(outd), 64'(i));
      chk("ind_d_valid", 64'(out_valid[3]), 64'h1);
      chk("ind_outa", 64'(outa), 64'hAAAA5555);
    end
    in_valid = 1'b0;
    tick();
    chk("ind_drained", 64'(out_valid), 64'h5);
    out_ready = 4'b0000;

    // Fill all channels, then async reset between edges
    inp      = 32'h11111111;
    set_sel(2'b01);
    in_valid = 1'b1;
    tick();
    inp = 32'h33333333;
    set_sel(2'b11);
    tick();
    in_valid = 1'b0;
    #1;
    chk("full_valid", 64'(out_valid), 64'hF);
    chk("full_outb", 64'(outb), 64'h11111111);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'h0);
    chk("arst_outa", 64'(outa), 64'h0);
    chk("arst_outc", 64'(outc), 64'h0);
    chk("arst_inrdy", 64'(in_ready), 64'h1);
    #1;
    rst_n = 1'b1;
    tick();
    chk("arst_after", 64'(out_valid), 64'h0);

`ifdef DEMUX_STATS_EN
    chk("cnt_rst", xfer_count, 64'h0);
    inp       = 32'h0000BEEF;
    set_sel(2'b01);
    in_valid  = 1'b1;
    out_ready = 4'b0010;
    for (int i = 0; i < 65537; i++) tick();
    in_valid = 1'b0;
    tick();
    out_ready = 4'b0000;
    #1;
    chk("cnt_wrap", xfer_count, 64'h0000_0000_0001_0000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
